// File: rtl/serial_divisibility_checker.sv
// Bit-serial MSB-first divisibility checker: keeps a running residue per divisor
// and reports word mod DIV_A, word mod DIV_B and the divisibility flags once per word.

module sdc_residue #(
  parameter int DIV = 3,
  parameter int RW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [RW-1:0] res,
  output logic [RW-1:0] res_nxt
);
  localparam logic [RW:0] DIV_T = (RW+1)'(DIV);

  logic [RW:0] t;

  // 2r+b is always below 2*DIV, so one conditional subtract keeps it reduced
  always_comb begin
    t       = {res, din};
    res_nxt = (t >= DIV_T) ? RW'(t - DIV_T) : RW'(t);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      res <= '0;
    else if (clr) res <= '0;
    else if (en)  res <= res_nxt;
  end
endmodule

module serial_divisibility_checker #(
  parameter  int WIDTH = 8,
  parameter  int DIV_A = 3,
  parameter  int DIV_B = 4,
  localparam int RW_A  = $clog2(DIV_A),
  localparam int RW_B  = $clog2(DIV_B)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            bit_valid_i,
  input  logic            bit_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_a_o,
  output logic            div_b_o,
  output logic            div_both_o,
  output logic [RW_A-1:0] res_a_o,
  output logic [RW_B-1:0] res_b_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept, last;
  logic [RW_A-1:0] ra, ra_nxt;
  logic [RW_B-1:0] rb, rb_nxt;

  // start_i wins over a bit arriving in the same cycle
  assign accept = (state_q == SHIFT) && bit_valid_i && !start_i;
  assign last   = accept && (cnt_q == LAST);

  sdc_residue #(.DIV(DIV_A), .RW(RW_A)) u_res_a (
    .clk(clk_i), .rst(rst_i), .clr(start_i), .en(accept), .din(bit_i),
    .res(ra), .res_nxt(ra_nxt)
  );

  sdc_residue #(.DIV(DIV_B), .RW(RW_B)) u_res_b (
    .clk(clk_i), .rst(rst_i), .clr(start_i), .en(accept), .din(bit_i),
    .res(rb), .res_nxt(rb_nxt)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = SHIFT;
      SHIFT:   if (!start_i && last) state_d = DONE;
      DONE:    state_d = start_i ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // count wraps to 0 on the last bit; start_i clears it in any state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        cnt_q <= '0;
    else if (start_i) cnt_q <= '0;
    else if (last)    cnt_q <= '0;
    else if (accept)  cnt_q <= cnt_q + 1'b1;
  end

  // results capture the post-update residues so they are valid in DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_a_o    <= '0;
      res_b_o    <= '0;
      div_a_o    <= 1'b0;
      div_b_o    <= 1'b0;
      div_both_o <= 1'b0;
    end else if (last) begin
      res_a_o    <= ra_nxt;
      res_b_o    <= rb_nxt;
      div_a_o    <= (ra_nxt == '0);
      div_b_o    <= (rb_nxt == '0);
      div_both_o <= (ra_nxt == '0) && (rb_nxt == '0);
    end
  end

  assign busy_o = (state_q == SHIFT);
  assign done_o = (state_q == DONE);

  logic unused_res;
  assign unused_res = ^{ra, rb};
endmodule

// File: tb/tb_serial_divisibility_checker.sv
// Scoreboard bench: default instance (8b, /3, /4) and a swept instance (12b, /7, /5).

module tb_serial_divisibility_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st_a, bv_a, bi_a, busy_a, done_a, da_a, db_a, dbo_a;
  logic [1:0] ra_a, rb_a;
  logic       st_b, bv_b, bi_b, busy_b, done_b, da_b, db_b, dbo_b;
  logic [2:0] ra_b, rb_b;

  serial_divisibility_checker #(.WIDTH(8), .DIV_A(3), .DIV_B(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(st_a), .bit_valid_i(bv_a), .bit_i(bi_a),
    .busy_o(busy_a), .done_o(done_a), .div_a_o(da_a), .div_b_o(db_a),
    .div_both_o(dbo_a), .res_a_o(ra_a), .res_b_o(rb_a)
  );

  serial_divisibility_checker #(.WIDTH(12), .DIV_A(7), .DIV_B(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(st_b), .bit_valid_i(bv_b), .bit_i(bi_b),
    .busy_o(busy_b), .done_o(done_b), .div_a_o(da_b), .div_b_o(db_b),
    .div_both_o(dbo_b), .res_a_o(ra_b), .res_b_o(rb_b)
  );

  typedef struct {
    int ra;
    int rb;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   dcnt_a = 0;
  int   dcnt_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      dcnt_a++;
      chk("a_busy_in_done", busy_a, 0);
      if (qa.size() == 0) chk("a_sb_empty", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_res_a", ra_a, e.ra);
        chk("a_res_b", rb_a, e.rb);
        chk("a_div_a", da_a, e.ra == 0);
        chk("a_div_b", db_a, e.rb == 0);
        chk("a_both",  dbo_a, (e.ra == 0) && (e.rb == 0));
      end
    end
    if (done_b) begin
      dcnt_b++;
      chk("b_busy_in_done", busy_b, 0);
      if (qb.size() == 0) chk("b_sb_empty", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_res_a", ra_b, e.ra);
        chk("b_res_b", rb_b, e.rb);
        chk("b_div_a", da_b, e.ra == 0);
        chk("b_div_b", db_b, e.rb == 0);
        chk("b_both",  dbo_b, (e.ra == 0) && (e.rb == 0));
      end
    end
  end

  task automatic drv(input int sel, input logic s, input logic v, input logic b);
    if (sel == 0) begin st_a = s; bv_a = v; bi_a = b; end
    else          begin st_b = s; bv_b = v; bi_b = b; end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Drives bits [w-1 -: n] of word; caller sits just after a negedge.
  task automatic drive_bits(input int sel, input logic [31:0] word, input int n, input bit gaps);
    int w;
    w = (sel == 0) ? 8 : 12;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          drv(sel, 1'b0, 1'b0, $urandom_range(0, 1));
          cyc();
        end
      end
      drv(sel, 1'b0, 1'b1, word[w-1-i]);
      cyc();
      drv(sel, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Full word; returns at the negedge of the cycle where done_o must be high.
  task automatic send_word(input int sel, input logic [31:0] word, input bit gaps);
    exp_t e;
    if (sel == 0) begin
      e.ra = int'(word[7:0]) % 3;  e.rb = int'(word[7:0]) % 4;  qa.push_back(e);
    end else begin
      e.ra = int'(word[11:0]) % 7; e.rb = int'(word[11:0]) % 5; qb.push_back(e);
    end
    drv(sel, 1'b1, 1'b0, 1'b0);
    cyc();
    drv(sel, 1'b0, 1'b0, 1'b0);
    drive_bits(sel, word, (sel == 0) ? 8 : 12, gaps);
    chk(sel == 0 ? "a_done_lat" : "b_done_lat", sel == 0 ? done_a : done_b, 1);
  endtask

  initial begin
    int d0;
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    rst = 1'b1;
    idle(2);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_flags", {da_a, db_a, dbo_a}, 0);
    chk("rst_res", {ra_a, rb_a}, 0);
    rst = 1'b0;
    idle(1);

    // word 12 contiguous
    send_word(0, 32'h0C, 0);
    idle(2);
    // 0x06 then 0xFF back-to-back, start in DONE
    send_word(0, 32'h06, 0);
    send_word(0, 32'hFF, 0);
    idle(2);
    // 0x0D with gaps
    send_word(0, 32'h0D, 1);
    idle(2);
    chk("hold_res_a", ra_a, 1);
    // bits without start in IDLE are ignored
    drive_bits(0, 32'hFF, 8, 0);
    chk("idle_busy", busy_a, 0);
    idle(2);

    // restart after 5 bits, then word 0
    d0 = dcnt_a;
    drv(0, 1'b1, 1'b0, 1'b0);
    cyc();
    drv(0, 1'b0, 1'b0, 1'b0);
    drive_bits(0, 32'hB7, 5, 0);
    chk("partial_busy", busy_a, 1);
    send_word(0, 32'h00, 0);
    idle(3);
    chk("restart_done_once", dcnt_a - d0, 1);
    chk("restart_both", dbo_a, 1);

    // async reset mid-word
    drv(0, 1'b1, 1'b0, 1'b0);
    cyc();
    drv(0, 1'b0, 1'b0, 1'b0);
    drive_bits(0, 32'hA5, 3, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_flags", {da_a, db_a, dbo_a}, 0);
    chk("arst_res", {ra_a, rb_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = dcnt_a;
    drive_bits(0, 32'hFF, 8, 0);
    idle(3);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_nodone", dcnt_a - d0, 0);
    send_word(0, 32'h09, 0);
    idle(2);

    // parameter sweep instance
    d0 = dcnt_b;
    for (int k = 0; k < 200; k++) begin
      send_word(1, $urandom_range(0, 4095), (k % 4) == 3);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    send_word(1, 32'h000, 0);
    send_word(1, 32'hFFF, 0);
    idle(3);
    chk("b_done_count", dcnt_b - d0, 202);
    chk("a_sb_drained", qa.size(), 0);
    chk("b_sb_drained", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
